// File: rtl/i2c_slave_regfile_if.sv
// I2C target bus bundle for i2c_slave_regfile.
//   scl_i, sda_i : pad inputs (asynchronous to clk)
//   sda_oe       : 1 = pull SDA low (open-drain enable)
//   reg_out      : flat register bank, reg k at [8k+7:8k]
//   wr_strobe    : one-clk pulse per committed register write
//   wr_index     : register index written, valid with wr_strobe
//   busy         : address-matched transaction in progress
interface i2c_slave_regfile_if #(
  parameter int unsigned NUM_REGS = 4
);
  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_oe;
  logic [NUM_REGS*8-1:0] reg_out;
  logic                  wr_strobe;
  logic [3:0]            wr_index;
  logic                  busy;

  modport slave (
    input  scl_i, sda_i,
    output sda_oe, reg_out, wr_strobe, wr_index, busy
  );

  modport master (
    output scl_i, sda_i,
    input  sda_oe, reg_out, wr_strobe, wr_index, busy
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target with a bank of NUM_REGS 8-bit registers behind an
// auto-incrementing pointer. SCL/SDA are oversampled on clk (2-FF sync plus
// FILTER_LEN glitch filter); SDA is driven only through an open-drain enable.
//   clk   : system clock, at least 16x SCL
//   rst_n : synchronous active-low reset
//   bus   : i2c_slave_regfile_if.slave (pads, register bank, write strobe, busy)
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h27,
  parameter int unsigned NUM_REGS   = 4,
  parameter logic [7:0]  REG_RST    = 8'h7E,
  parameter int unsigned FILTER_LEN = 3
) (
  input logic                clk,
  input logic                rst_n,
  i2c_slave_regfile_if.slave bus
);

  localparam int unsigned PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_ACK, S_IGNORE
  } state_t;

  // Input conditioning
  logic [1:0] scl_sync_q, sda_sync_q;
  logic [2:0] scl_cnt_q, sda_cnt_q;
  logic       scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;

  // A filtered level only follows the synchronised input once it has held
  // the new value for FILTER_LEN consecutive clocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[0], bus.sda_i};
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == 3'(FILTER_LEN - 1)) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 3'd1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == 3'(FILTER_LEN - 1)) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 3'd1;
      end
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q & scl_prev_q;
  assign start_det = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

  // Protocol state
  state_t                     state_q, state_d;
  logic [3:0]                 bitcnt_q, bitcnt_d;
  logic [7:0]                 shift_q, shift_d;
  logic [PW-1:0]              ptr_q, ptr_d, ptr_inc;
  logic                       rw_q, rw_d;
  logic                       mack_q, mack_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
  logic                       sda_oe_q, sda_oe_d;
  logic                       wr_strobe_q, wr_strobe_d;
  logic [3:0]                 wr_index_q, wr_index_d;
  logic                       busy_q, busy_d;
  logic                       byte_done, load_rd;

  assign ptr_inc   = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
  assign byte_done = scl_fall && (bitcnt_q == 4'd8);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    regs_d      = regs_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    busy_d      = busy_q;
    load_rd     = 1'b0;

    if (stop_det) begin
      state_d  = S_IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else begin
      if ((state_q == S_ADDR || state_q == S_PTR || state_q == S_WDATA) && scl_rise) begin
        shift_d  = {shift_q[6:0], sda_f_q};
        bitcnt_d = bitcnt_q + 4'd1;
      end
      case (state_q)
        S_ADDR: if (byte_done) begin
          bitcnt_d = '0;
          if (shift_q[7:1] == SLAVE_ADDR) begin
            state_d  = S_ADDR_ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = shift_q[0];
          end else begin
            state_d = S_IGNORE;
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (rw_q) begin
            load_rd = 1'b1;
          end else begin
            state_d  = S_PTR;
            sda_oe_d = 1'b0;
          end
        end
        S_PTR: if (byte_done) begin
          bitcnt_d = '0;
          if (shift_q < 8'(NUM_REGS)) begin
            ptr_d    = shift_q[PW-1:0];
            sda_oe_d = 1'b1;
            state_d  = S_PTR_ACK;
          end else begin
            state_d = S_IGNORE;
          end
        end
        S_WDATA: if (byte_done) begin
          bitcnt_d      = '0;
          regs_d[ptr_q] = shift_q;
          wr_strobe_d   = 1'b1;
          wr_index_d    = 4'(ptr_q);
          ptr_d         = ptr_inc;
          sda_oe_d      = 1'b1;
          state_d       = S_WDATA_ACK;
        end
        S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = S_WDATA;
        end
        S_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            mack_d = sda_f_q;
          end else if (scl_fall) begin
            if (!mack_q) load_rd = 1'b1;
            else         state_d = S_IGNORE;
          end
        end
        default: ;
      endcase

      // Read byte load: reads the registered bank, so a same-clk write to
      // this register is not visible until the next load.
      if (load_rd) begin
        shift_d  = regs_q[ptr_q];
        sda_oe_d = ~regs_q[ptr_q][7];
        ptr_d    = ptr_inc;
        bitcnt_d = '0;
        state_d  = S_RDATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      regs_q      <= {NUM_REGS{REG_RST}};
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      regs_q      <= regs_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_out   = regs_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_index  = wr_index_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master drives the
// pads with an open-drain SDA line model; expected values are hand-computed.
module tb_i2c_slave_regfile;

  localparam int Q = 8;  // clks per quarter SCL period

  logic clk = 1'b0;
  logic rst_n;
  logic sda_m;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int oe_cnt     = 0;
  int busy_cnt   = 0;
  logic [3:0] idx_log [0:31];

  int   s_base, o_base, b_base;
  logic ack, r;
  logic [7:0] d1, d2;

  always #5 clk = ~clk;

  i2c_slave_regfile_if #(.NUM_REGS(4)) bus ();

  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_slave_regfile #(
    .SLAVE_ADDR(7'h27),
    .NUM_REGS  (4),
    .REG_RST   (8'h7E),
    .FILTER_LEN(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      if (strobe_cnt < 32) idx_log[strobe_cnt] = bus.wr_index;
      strobe_cnt++;
    end
    if (bus.sda_oe) oe_cnt++;
    if (bus.busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period; SCL low on entry and exit. Optional 2-clk SCL low glitch
  // in the middle of the high phase.
  task automatic i2c_bit(input logic b, input bit glitch, output logic rd);
    clks(Q);
    sda_m = b;
    clks(Q);
    bus.scl_i = 1'b1;
    clks(Q);
    if (glitch) begin
      bus.scl_i = 1'b0;
      clks(2);
      bus.scl_i = 1'b1;
    end
    rd = bus.sda_i;
    clks(Q);
    bus.scl_i = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    clks(Q);
    bus.scl_i = 1'b1;
    clks(Q);
    sda_m = 1'b0;
    clks(Q);
    bus.scl_i = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(Q);
    sda_m = 1'b0;
    clks(Q);
    bus.scl_i = 1'b1;
    clks(Q);
    sda_m = 1'b1;
    clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic got_ack);
    logic x;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], (i == glitch_bit), x);
    i2c_bit(1'b1, 1'b0, x);
    got_ack = ~x;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic x;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, 1'b0, x);
      d = {d[6:0], x};
    end
    i2c_bit(nack, 1'b0, x);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.scl_i = 1'b1;
    sda_m     = 1'b1;
    clks(5);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_reg_out", bus.reg_out, 32'h7E7E7E7E);
    chk("rst_wr_strobe", bus.wr_strobe, 0);
    chk("rst_wr_index", bus.wr_index, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    clks(20);

    // Single write: reg1 <= 0x8D
    s_base = strobe_cnt;
    i2c_start();
    send_byte(8'h4E, -1, ack); chk("w1_addr_ack", ack, 1);
    send_byte(8'h01, -1, ack); chk("w1_ptr_ack", ack, 1);
    send_byte(8'h8D, -1, ack); chk("w1_data_ack", ack, 1);
    chk("w1_busy", bus.busy, 1);
    i2c_stop();
    chk("w1_reg_out", bus.reg_out, 32'h7E7E8D7E);
    chk("w1_strobes", strobe_cnt - s_base, 1);
    chk("w1_index", idx_log[s_base], 1);
    chk("w1_busy_after_stop", bus.busy, 0);

    // Wrapping burst from reg3
    s_base = strobe_cnt;
    i2c_start();
    send_byte(8'h4E, -1, ack); chk("wb_addr_ack", ack, 1);
    send_byte(8'h03, -1, ack); chk("wb_ptr_ack", ack, 1);
    send_byte(8'hA1, -1, ack); chk("wb_d0_ack", ack, 1);
    send_byte(8'hB2, -1, ack); chk("wb_d1_ack", ack, 1);
    send_byte(8'hC3, -1, ack); chk("wb_d2_ack", ack, 1);
    i2c_stop();
    chk("wb_reg_out", bus.reg_out, 32'hA17EC3B2);
    chk("wb_strobes", strobe_cnt - s_base, 3);
    chk("wb_index0", idx_log[s_base], 3);
    chk("wb_index1", idx_log[s_base + 1], 0);
    chk("wb_index2", idx_log[s_base + 2], 1);

    // Repeated-START read of reg1, reg2
    s_base = strobe_cnt;
    i2c_start();
    send_byte(8'h4E, -1, ack); chk("rd_waddr_ack", ack, 1);
    send_byte(8'h01, -1, ack); chk("rd_ptr_ack", ack, 1);
    i2c_start();
    send_byte(8'h4F, -1, ack); chk("rd_raddr_ack", ack, 1);
    recv_byte(1'b0, d1);
    recv_byte(1'b1, d2);
    chk("rd_byte0", d1, 8'hC3);
    chk("rd_byte1", d2, 8'h7E);
    clks(Q);
    chk("rd_released_after_nack", bus.sda_oe, 0);
    i2c_stop();
    chk("rd_no_strobe", strobe_cnt - s_base, 0);
    chk("rd_busy_after_stop", bus.busy, 0);

    // Address 0x28 is not ours
    o_base = oe_cnt;
    b_base = busy_cnt;
    i2c_start();
    send_byte(8'h50, -1, ack); chk("rej_addr_nack", ack, 0);
    send_byte(8'h11, -1, ack); chk("rej_addr_data_nack", ack, 0);
    i2c_stop();
    chk("rej_addr_no_drive", oe_cnt - o_base, 0);
    chk("rej_addr_no_busy", busy_cnt - b_base, 0);

    // Pointer 0x04 out of range; pointer stays at 3
    s_base = strobe_cnt;
    i2c_start();
    send_byte(8'h4E, -1, ack); chk("rej_ptr_addr_ack", ack, 1);
    send_byte(8'h04, -1, ack); chk("rej_ptr_nack", ack, 0);
    send_byte(8'h55, -1, ack); chk("rej_ptr_data_nack", ack, 0);
    i2c_stop();
    chk("rej_ptr_no_strobe", strobe_cnt - s_base, 0);
    chk("rej_ptr_reg_out", bus.reg_out, 32'hA17EC3B2);
    i2c_start();
    send_byte(8'h4F, -1, ack); chk("rej_ptr_raddr_ack", ack, 1);
    recv_byte(1'b1, d1);
    chk("rej_ptr_kept", d1, 8'hA1);
    i2c_stop();

    // STOP after 5 data bits discards the partial byte
    s_base = strobe_cnt;
    i2c_start();
    send_byte(8'h4E, -1, ack); chk("ab_addr_ack", ack, 1);
    send_byte(8'h00, -1, ack); chk("ab_ptr_ack", ack, 1);
    for (int i = 0; i < 5; i++) i2c_bit(1'b1, 1'b0, r);
    i2c_stop();
    chk("ab_reg_out", bus.reg_out, 32'hA17EC3B2);
    chk("ab_no_strobe", strobe_cnt - s_base, 0);
    chk("ab_busy", bus.busy, 0);
    chk("ab_sda_oe", bus.sda_oe, 0);

    // 2-clk SCL glitch inside a data bit is filtered out
    s_base = strobe_cnt;
    i2c_start();
    send_byte(8'h4E, -1, ack); chk("gl_addr_ack", ack, 1);
    send_byte(8'h02, -1, ack); chk("gl_ptr_ack", ack, 1);
    send_byte(8'h5A, 4, ack);  chk("gl_data_ack", ack, 1);
    i2c_stop();
    chk("gl_reg_out", bus.reg_out, 32'hA15AC3B2);
    chk("gl_strobes", strobe_cnt - s_base, 1);
    chk("gl_index", idx_log[s_base], 2);

    // Reset while the target drives a 0 read bit (reg3 = 0xA1, bit6 = 0)
    i2c_start();
    send_byte(8'h4F, -1, ack); chk("rr_addr_ack", ack, 1);
    i2c_bit(1'b1, 1'b0, r);
    chk("rr_bit7", r, 1);
    clks(Q);
    chk("rr_driving", bus.sda_oe, 1);
    chk("rr_busy", bus.busy, 1);
    rst_n = 1'b0;
    clks(1);
    chk("rr_sda_oe", bus.sda_oe, 0);
    chk("rr_reg_out", bus.reg_out, 32'h7E7E7E7E);
    chk("rr_busy_rst", bus.busy, 0);
    chk("rr_wr_strobe", bus.wr_strobe, 0);
    chk("rr_wr_index", bus.wr_index, 0);
    bus.scl_i = 1'b1;
    sda_m     = 1'b1;
    clks(10);
    rst_n = 1'b1;
    clks(20);
    chk("rr_idle_busy", bus.busy, 0);
    chk("rr_idle_sda_oe", bus.sda_oe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
